// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared constants and types for the Kyber modular multiplier
package kyber_pkg;

  localparam logic [11:0] KYBER_Q = 12'd3329;
  localparam logic [12:0] BAR_M   = 13'd5039;
  localparam int          BAR_K   = 24;
  localparam int          CNT_W   = 16;

  typedef logic [11:0] coef_t;
  typedef logic [23:0] prod_t;

  typedef struct packed {
    logic  valid;
    logic  id;
    prod_t payload;
  } mm_stage_t;

endpackage

// File: rtl/kyber_modmul_arb_rr_arb2.sv
// rtl/kyber_modmul_arb_rr_arb2.sv - two-way round-robin arbiter with advance enable
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant the lone requester, or the pointer's choice when both ask; nothing while held or in reset.
  always_comb begin
    gnt = 2'b00;
    if (en && rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After any grant the pointer moves to the requester that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/kyber_modmul_arb.sv
// rtl/kyber_modmul_arb.sv - arbitrated two-stage (a*b) mod 3329 Barrett multiplier
module kyber_modmul_arb
  import kyber_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [23:0]          req_a,
  input  logic [23:0]          req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [11:0]          rsp_data,
  output logic [2*CNT_W-1:0]   done_cnt,
  output logic                 busy
);

  mm_stage_t        s1;
  mm_stage_t        s2;
  logic             adv;
  logic [1:0]       gnt;
  coef_t            a_sel;
  coef_t            b_sel;
  prod_t            prod;
  logic [36:0]      pm;
  logic [12:0]      qhat;
  logic [24:0]      qq;
  logic [13:0]      r0;
  logic [13:0]      r1;
  logic [13:0]      r2;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  assign adv = !s2.valid || rsp_ready;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (adv),
    .gnt   (gnt)
  );

  assign req_ready = gnt;

  // Operand mux and full 24-bit product for the granted requester.
  always_comb begin
    a_sel = gnt[1] ? req_a[23:12] : req_a[11:0];
    b_sel = gnt[1] ? req_b[23:12] : req_b[11:0];
    prod  = 24'(a_sel) * 24'(b_sel);
  end

  // Barrett reduction of the S1 product; 37-bit intermediate and 13-bit quotient keep it exact up to 4095*4095.
  always_comb begin
    pm   = 37'(s1.payload) * 37'(BAR_M);
    qhat = pm[36:BAR_K];
    qq   = 25'(qhat) * 25'(KYBER_Q);
    r0   = s1.payload[13:0] - qq[13:0];
    r1   = (r0 >= 14'(KYBER_Q)) ? r0 - 14'(KYBER_Q) : r0;
    r2   = (r1 >= 14'(KYBER_Q)) ? r1 - 14'(KYBER_Q) : r1;
  end

  // Both stages move together on advance; payloads only load on real entries so bubbles never carry stray operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (adv) begin
      s1.valid <= |gnt;
      s1.id    <= gnt[1];
      if (|gnt) begin
        s1.payload <= prod;
      end
      s2.valid <= s1.valid;
      s2.id    <= s1.id;
      if (s1.valid) begin
        s2.payload <= {12'd0, r2[11:0]};
      end
    end
  end

  // Per-requester completion counters, bumped on each retired response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (s2.valid && rsp_ready) begin
      if (s2.id) begin
        cnt1 <= cnt1 + 1'b1;
      end else begin
        cnt0 <= cnt0 + 1'b1;
      end
    end
  end

  assign rsp_valid = s2.valid;
  assign rsp_id    = s2.id;
  assign rsp_data  = s2.payload[11:0];
  assign done_cnt  = {cnt1, cnt0};
  assign busy      = s1.valid | s2.valid;

endmodule
